// File: rtl/regfile_bypass_sb.sv
// Register file with one byte-enabled write port, two registered write-first read ports,
// optional hardwired-zero entry 0 and a per-entry busy scoreboard for RAW hazard detection.
module regfile_bypass_sb #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 2,
  parameter bit          R0_ZERO = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  output logic                rd_valid,
  input  logic                sb_set_en,
  input  logic [ADDR_W-1:0]   sb_set_addr,
  output logic                busy1,
  output logic                busy2
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned NumBytes = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [Depth];
  logic [Depth-1:0]  r_busy;
  logic [DATA_W-1:0] r_rd_data1;
  logic [DATA_W-1:0] r_rd_data2;
  logic              r_rd_valid;

  logic              w_wr_hit;
  logic              w_set_ok;
  logic [DATA_W-1:0] w_wr_val;
  logic [DATA_W-1:0] w_rd1_val;
  logic [DATA_W-1:0] w_rd2_val;
  logic [Depth-1:0]  w_busy_d;

  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0]   old_val,
                                                 input logic [DATA_W-1:0]   new_val,
                                                 input logic [NumBytes-1:0] be);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(NumBytes); i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Entry 0 is never stored or marked busy when it is hardwired to zero.
  assign w_wr_hit = wr_en && !(R0_ZERO && (wr_addr == '0));
  assign w_set_ok = sb_set_en && !(R0_ZERO && (sb_set_addr == '0));
  assign w_wr_val = f_merge(r_mem[wr_addr], wr_data, wr_be);

  always_comb begin
    w_rd1_val = r_mem[rd_addr1];
    if (w_wr_hit && (wr_addr == rd_addr1)) w_rd1_val = w_wr_val;
    if (R0_ZERO && (rd_addr1 == '0)) w_rd1_val = '0;
    w_rd2_val = r_mem[rd_addr2];
    if (w_wr_hit && (wr_addr == rd_addr2)) w_rd2_val = w_wr_val;
    if (R0_ZERO && (rd_addr2 == '0)) w_rd2_val = '0;
  end

  // Set is applied after clear so a newly issued producer supersedes the retiring one.
  always_comb begin
    w_busy_d = r_busy;
    if (wr_en) w_busy_d[wr_addr] = 1'b0;
    if (w_set_ok) w_busy_d[sb_set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
      r_busy     <= '0;
      r_rd_data1 <= '0;
      r_rd_data2 <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_hit) r_mem[wr_addr] <= w_wr_val;
      r_busy     <= w_busy_d;
      r_rd_data1 <= rd_en ? w_rd1_val : '0;
      r_rd_data2 <= rd_en ? w_rd2_val : '0;
      r_rd_valid <= rd_en;
    end
  end

  // A write landing this cycle is forwarded by the bypass, so it does not count as busy.
  assign busy1 = r_busy[rd_addr1] && !(wr_en && (wr_addr == rd_addr1));
  assign busy2 = r_busy[rd_addr2] && !(wr_en && (wr_addr == rd_addr2));

  assign rd_data1 = r_rd_data1;
  assign rd_data2 = r_rd_data2;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: directed scenarios then random traffic on a plain instance and an
// R0_ZERO instance, both checked against an array-based reference model.
module tb_regfile_bypass_sb;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        rd_en;
  logic [1:0]  rd_addr1;
  logic [1:0]  rd_addr2;
  logic        sb_set_en;
  logic [1:0]  sb_set_addr;

  logic [15:0] rd_data1 [2];
  logic [15:0] rd_data2 [2];
  logic        rd_valid [2];
  logic        busy1 [2];
  logic        busy2 [2];

  int total = 0;
  int bad = 0;

  // Reference model state, index 0 = plain instance, 1 = R0_ZERO instance.
  logic [15:0] m_mem  [2][4];
  bit          m_busy [2][4];
  logic [15:0] m_rd1  [2];
  logic [15:0] m_rd2  [2];
  logic        m_val  [2];

  regfile_bypass_sb #(.DATA_W(16), .ADDR_W(2), .R0_ZERO(1'b0)) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1[0]), .rd_data2(rd_data2[0]), .rd_valid(rd_valid[0]),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy1(busy1[0]), .busy2(busy2[0])
  );

  regfile_bypass_sb #(.DATA_W(16), .ADDR_W(2), .R0_ZERO(1'b1)) u_dut_z (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1[1]), .rd_data2(rd_data2[1]), .rd_valid(rd_valid[1]),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy1(busy1[1]), .busy2(busy2[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 4; a++) begin
        m_mem[k][a]  = 16'h0;
        m_busy[k][a] = 1'b0;
      end
      m_rd1[k] = 16'h0;
      m_rd2[k] = 16'h0;
      m_val[k] = 1'b0;
    end
  endtask

  // One clock: check combinational busy, advance the model, then check registered outputs.
  task automatic tick(input string tag);
    logic [15:0] nv;
    logic [15:0] byte_mask;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk({tag, "/busy1"}, busy1[k],
          m_busy[k][rd_addr1] && !(wr_en && wr_addr == rd_addr1));
      chk({tag, "/busy2"}, busy2[k],
          m_busy[k][rd_addr2] && !(wr_en && wr_addr == rd_addr2));
    end
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int a = 0; a < 4; a++) begin
          m_mem[k][a]  = 16'h0;
          m_busy[k][a] = 1'b0;
        end
        m_rd1[k] = 16'h0;
        m_rd2[k] = 16'h0;
        m_val[k] = 1'b0;
      end else begin
        if (wr_en && !(k == 1 && wr_addr == 2'd0)) begin
          byte_mask = (wr_be[0] ? 16'h00FF : 16'h0) | (wr_be[1] ? 16'hFF00 : 16'h0);
          nv = (m_mem[k][wr_addr] & ~byte_mask) | (wr_data & byte_mask);
          m_mem[k][wr_addr] = nv;
        end
        // Write-first: reads see the entry after this cycle's write.
        if (rd_en) begin
          m_rd1[k] = m_mem[k][rd_addr1];
          m_rd2[k] = m_mem[k][rd_addr2];
          m_val[k] = 1'b1;
        end else begin
          m_rd1[k] = 16'h0;
          m_rd2[k] = 16'h0;
          m_val[k] = 1'b0;
        end
        if (wr_en) m_busy[k][wr_addr] = 1'b0;
        if (sb_set_en && !(k == 1 && sb_set_addr == 2'd0)) m_busy[k][sb_set_addr] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk({tag, "/rd_data1"}, rd_data1[k], m_rd1[k]);
      chk({tag, "/rd_data2"}, rd_data2[k], m_rd2[k]);
      chk({tag, "/rd_valid"}, rd_valid[k], m_val[k]);
    end
  endtask

  task automatic idle();
    reset = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 16'h0; wr_be = 2'b00;
    rd_en = 1'b0; rd_addr1 = 2'd0; rd_addr2 = 2'd0; sb_set_en = 1'b0; sb_set_addr = 2'd0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic rd(input logic [1:0] a1, input logic [1:0] a2);
    rd_en = 1'b1; rd_addr1 = a1; rd_addr2 = a2;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_clear();

    // Reset clears contents written beforehand; rd_valid low for the reset cycle.
    for (int a = 0; a < 4; a++) begin
      idle(); wr(2'(a), 16'hBEEF, 2'b11); sb_set_en = 1'b1; sb_set_addr = 2'(3 - a);
      tick("t1_fill");
    end
    idle(); rd(2'd1, 2'd2); reset = 1'b1; wr(2'd0, 16'hBEEF, 2'b11);
    tick("t1_reset");
    chk("t1_valid_in_reset", rd_valid[0], 1'b0);
    for (int a = 0; a < 4; a++) begin
      idle(); rd(2'(a), 2'(3 - a));
      tick("t1_read");
      chk("t1_zero", rd_data1[0], 16'h0000);
    end

    // Plain write then read, then rd_en low zeroes outputs.
    idle(); wr(2'd2, 16'h1234, 2'b11); tick("t2_wr");
    idle(); rd(2'd2, 2'd2); tick("t2_rd");
    chk("t2_data1", rd_data1[0], 16'h1234);
    chk("t2_data2", rd_data2[0], 16'h1234);
    idle(); tick("t2_idle");

    // Byte-enable merge through the bypass path.
    idle(); wr(2'd1, 16'hAAAA, 2'b11); tick("t3_init");
    idle(); wr(2'd1, 16'h5555, 2'b01); rd(2'd1, 2'd3); tick("t3_bypass");
    chk("t3_merge", rd_data1[0], 16'hAA55);
    idle(); rd(2'd1, 2'd1); tick("t3_reread");
    chk("t3_hold", rd_data2[0], 16'hAA55);
    idle(); wr(2'd2, 16'h9999, 2'b00); rd(2'd2, 2'd2); tick("t3_be0");

    // Scoreboard set, bypassed clear, same-cycle set+clear.
    idle(); sb_set_en = 1'b1; sb_set_addr = 2'd3; rd_addr1 = 2'd3; tick("t4_set");
    idle(); rd_addr1 = 2'd3; #1; chk("t4_busy", busy1[0], 1'b1); tick("t4_busy_hold");
    idle(); rd_addr1 = 2'd3; wr(2'd3, 16'hC0DE, 2'b11); #1;
    chk("t4_bypass_busy", busy1[0], 1'b0); tick("t4_clear");
    idle(); rd_addr1 = 2'd3; tick("t4_after");
    idle(); sb_set_en = 1'b1; sb_set_addr = 2'd3; wr(2'd3, 16'h0BAD, 2'b11);
    rd_addr1 = 2'd3; tick("t4_setwins");
    idle(); rd_addr1 = 2'd3; #1; chk("t4_still_busy", busy1[0], 1'b1); tick("t4_end");

    // Entry 0 behaviour on both instances.
    idle(); wr(2'd0, 16'hFFFF, 2'b11); rd(2'd0, 2'd0); tick("t5_r0_wr");
    chk("t5_r0_read", rd_data1[1], 16'h0000);
    chk("t5_plain_read", rd_data1[0], 16'hFFFF);
    idle(); sb_set_en = 1'b1; sb_set_addr = 2'd0; tick("t5_r0_set");
    idle(); rd(2'd0, 2'd0); tick("t5_r0_busy");

    // Reset mid-operation wins over a concurrent write, read and busy state.
    idle(); sb_set_en = 1'b1; sb_set_addr = 2'd1; tick("t6_set");
    idle(); reset = 1'b1; wr(2'd1, 16'h7777, 2'b11); rd(2'd1, 2'd1); tick("t6_reset");
    idle(); rd(2'd1, 2'd1); tick("t6_read");
    chk("t6_entry1", rd_data1[0], 16'h0000);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 39) == 0);
      wr_en       = $urandom_range(0, 1) == 1;
      wr_addr     = 2'($urandom_range(0, 3));
      wr_data     = 16'($urandom);
      wr_be       = 2'($urandom_range(0, 3));
      rd_en       = $urandom_range(0, 3) != 0;
      rd_addr1    = 2'($urandom_range(0, 3));
      rd_addr2    = 2'($urandom_range(0, 3));
      sb_set_en   = $urandom_range(0, 2) == 0;
      sb_set_addr = 2'($urandom_range(0, 3));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
